// File: rtl/nv_nvdla_cmac_layer_ctrl.sv
// CMAC layer controller: ping-pong sequencing of the two dual register groups,
// write locking of armed groups, and datapath launch/retire handshake.
module nv_nvdla_cmac_layer_ctrl #(
    parameter int         CNT_W    = 8,
    parameter logic [1:0] PREC_RST = 2'b01
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg_wr_en,
    input  logic             reg_wr_data0,
    input  logic             producer,
    input  logic             op_en_trigger_0,
    input  logic             op_en_trigger_1,
    input  logic             conv_mode_0,
    input  logic [1:0]       proc_precision_0,
    input  logic             conv_mode_1,
    input  logic [1:0]       proc_precision_1,
    input  logic             dp2reg_done,
    output logic             dual_reg_wr_en_0,
    output logic             dual_reg_wr_en_1,
    output logic             op_en_0,
    output logic             op_en_1,
    output logic             consumer,
    output logic             reg2dp_op_en,
    output logic             reg2dp_conv_mode,
    output logic [1:0]       reg2dp_proc_precision,
    output logic [CNT_W-1:0] layer_cnt,
    output logic             err_unexp_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             op_en_0_q, op_en_1_q;
    logic             consumer_q;
    logic             conv_mode_q;
    logic [1:0]       precision_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             cons_op_en;
    logic             retire_0, retire_1;

    assign cons_op_en = consumer_q ? op_en_1_q : op_en_0_q;
    assign retire_0   = (state_q == DONE) & ~consumer_q;
    assign retire_1   = (state_q == DONE) &  consumer_q;

    // An armed group is frozen until hardware retires it, OP_ENABLE included.
    assign dual_reg_wr_en_0 = reg_wr_en & ~producer & ~op_en_0_q;
    assign dual_reg_wr_en_1 = reg_wr_en &  producer & ~op_en_1_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cons_op_en) state_d = START;
            START:   state_d = RUN;
            RUN:     if (dp2reg_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= IDLE;
            op_en_0_q   <= 1'b0;
            op_en_1_q   <= 1'b0;
            consumer_q  <= 1'b0;
            conv_mode_q <= 1'b0;
            precision_q <= PREC_RST;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Retire takes priority over a software trigger on the same group.
            if (retire_0)             op_en_0_q <= 1'b0;
            else if (op_en_trigger_0) op_en_0_q <= reg_wr_data0;
            if (retire_1)             op_en_1_q <= 1'b0;
            else if (op_en_trigger_1) op_en_1_q <= reg_wr_data0;

            if (state_q == START) begin
                conv_mode_q <= consumer_q ? conv_mode_1      : conv_mode_0;
                precision_q <= consumer_q ? proc_precision_1 : proc_precision_0;
            end

            if (state_q == DONE) begin
                consumer_q <= ~consumer_q;
                cnt_q      <= cnt_q + CNT_W'(1);
            end

            if (dp2reg_done && (state_q != RUN)) err_q <= 1'b1;
        end
    end

    assign op_en_0               = op_en_0_q;
    assign op_en_1               = op_en_1_q;
    assign consumer              = consumer_q;
    assign reg2dp_op_en          = (state_q == RUN);
    assign reg2dp_conv_mode      = conv_mode_q;
    assign reg2dp_proc_precision = precision_q;
    assign layer_cnt             = cnt_q;
    assign err_unexp_done        = err_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_layer_ctrl.sv
// Directed self-checking bench for nv_nvdla_cmac_layer_ctrl.
module tb_nv_nvdla_cmac_layer_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       reg_wr_en = 1'b0, reg_wr_data0 = 1'b0, producer = 1'b0;
    logic       trig0 = 1'b0, trig1 = 1'b0;
    logic       conv_mode_0 = 1'b0, conv_mode_1 = 1'b0;
    logic [1:0] prec_0 = 2'b00, prec_1 = 2'b00;
    logic       done = 1'b0;
    logic       wr_en_0, wr_en_1, op_en_0, op_en_1, consumer, dp_op_en, dp_conv;
    logic [1:0] dp_prec;
    logic [7:0] layer_cnt;
    logic       err;

    int passCount = 0;
    int checkCount = 0;
    logic expCons;
    logic [7:0] expCnt;

    nv_nvdla_cmac_layer_ctrl #(.CNT_W(8), .PREC_RST(2'b01)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rstn(rstn),
        .reg_wr_en(reg_wr_en),
        .reg_wr_data0(reg_wr_data0),
        .producer(producer),
        .op_en_trigger_0(trig0),
        .op_en_trigger_1(trig1),
        .conv_mode_0(conv_mode_0),
        .proc_precision_0(prec_0),
        .conv_mode_1(conv_mode_1),
        .proc_precision_1(prec_1),
        .dp2reg_done(done),
        .dual_reg_wr_en_0(wr_en_0),
        .dual_reg_wr_en_1(wr_en_1),
        .op_en_0(op_en_0),
        .op_en_1(op_en_1),
        .consumer(consumer),
        .reg2dp_op_en(dp_op_en),
        .reg2dp_conv_mode(dp_conv),
        .reg2dp_proc_precision(dp_prec),
        .layer_cnt(layer_cnt),
        .err_unexp_done(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic t0, input logic t1, input logic d0, input logic dn);
        trig0        = t0;
        trig1        = t1;
        reg_wr_data0 = d0;
        done         = dn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset values
        #12;
        checkOutput("rst_op_en_0", op_en_0, 0);
        checkOutput("rst_op_en_1", op_en_1, 0);
        checkOutput("rst_consumer", consumer, 0);
        checkOutput("rst_dp_op_en", dp_op_en, 0);
        checkOutput("rst_conv", dp_conv, 0);
        checkOutput("rst_prec", dp_prec, 2'b01);
        checkOutput("rst_cnt", layer_cnt, 0);
        checkOutput("rst_err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Launch group 0
        conv_mode_0 = 1'b1; prec_0 = 2'b11;
        conv_mode_1 = 1'b1; prec_1 = 2'b10;
        producer = 1'b0; reg_wr_en = 1'b1;
        applyStimulus(1, 0, 1, 0);
        #1;
        checkOutput("wr_en_0_unlocked", wr_en_0, 1);
        checkOutput("wr_en_1_wrong_prod", wr_en_1, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("op_en_0_T1", op_en_0, 1);
        checkOutput("wr_en_0_locked", wr_en_0, 0);
        checkOutput("dp_op_en_T1", dp_op_en, 0);
        reg_wr_en = 1'b0;
        step();
        checkOutput("dp_op_en_START", dp_op_en, 0);
        checkOutput("prec_before_load", dp_prec, 2'b01);
        step();
        checkOutput("dp_op_en_T3", dp_op_en, 1);
        checkOutput("conv_g0", dp_conv, 1);
        checkOutput("prec_g0", dp_prec, 2'b11);

        // Field change during RUN must not reach datapath
        conv_mode_0 = 1'b0;
        step();
        checkOutput("conv_held_run", dp_conv, 1);

        // Arm group 1 while group 0 runs
        producer = 1'b1; reg_wr_en = 1'b1;
        #1;
        checkOutput("wr_en_1_unlocked", wr_en_1, 1);
        checkOutput("wr_en_0_prod1", wr_en_0, 0);
        applyStimulus(0, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        reg_wr_en = 1'b0;
        checkOutput("op_en_1_pending", op_en_1, 1);
        checkOutput("consumer_still0", consumer, 0);
        checkOutput("dp_op_en_still_run", dp_op_en, 1);

        // Retire group 0, back-to-back into group 1
        applyStimulus(0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0);
        checkOutput("dp_op_en_DONE", dp_op_en, 0);
        step();
        checkOutput("op_en_0_cleared", op_en_0, 0);
        checkOutput("consumer_1", consumer, 1);
        checkOutput("cnt_1", layer_cnt, 1);
        checkOutput("dp_op_en_IDLE", dp_op_en, 0);
        step();
        checkOutput("dp_op_en_START2", dp_op_en, 0);
        step();
        checkOutput("dp_op_en_g1", dp_op_en, 1);
        checkOutput("conv_g1", dp_conv, 1);
        checkOutput("prec_g1", dp_prec, 2'b10);
        checkOutput("err_clean", err, 0);

        // Retire group 1
        applyStimulus(0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0);
        step();
        checkOutput("consumer_back0", consumer, 0);
        checkOutput("cnt_2", layer_cnt, 2);
        checkOutput("op_en_1_cleared", op_en_1, 0);

        // Unexpected done while idle
        applyStimulus(0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0);
        checkOutput("err_set", err, 1);
        checkOutput("cnt_unchanged", layer_cnt, 2);
        checkOutput("idle_no_run", dp_op_en, 0);
        step();
        step();
        checkOutput("err_sticky", err, 1);
        checkOutput("state_still_idle", dp_op_en, 0);

        // Run remaining layers up to counter wrap
        expCons = 1'b0;
        expCnt  = 8'd2;
        for (int l = 0; l < 254; l++) begin
            applyStimulus(~expCons, expCons, 1, 0);
            step();
            applyStimulus(0, 0, 0, 0);
            step();
            step();
            applyStimulus(0, 0, 0, 1);
            step();
            applyStimulus(0, 0, 0, 0);
            step();
            expCons = ~expCons;
            expCnt  = expCnt + 8'd1;
            if (l == 252) begin
                checkOutput("cnt_255", layer_cnt, expCnt);
                checkOutput("consumer_at_255", consumer, expCons);
            end
        end
        checkOutput("cnt_wrap", layer_cnt, 0);
        checkOutput("consumer_wrap", consumer, 0);

        // Async reset mid-layer
        applyStimulus(1, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        step();
        step();
        checkOutput("pre_rst_run", dp_op_en, 1);
        checkOutput("pre_rst_prec", dp_prec, 2'b11);
        checkOutput("pre_rst_op_en_1", op_en_1, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst_dp_op_en", dp_op_en, 0);
        checkOutput("arst_op_en_0", op_en_0, 0);
        checkOutput("arst_op_en_1", op_en_1, 0);
        checkOutput("arst_prec", dp_prec, 2'b01);
        checkOutput("arst_conv", dp_conv, 0);
        checkOutput("arst_cnt", layer_cnt, 0);
        checkOutput("arst_err", err, 0);
        checkOutput("arst_consumer", consumer, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
